// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with enable, clear, clamped load, wrap or
// saturate boundary handling, combinational terminal count and wrap/overflow flags.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             at_top;
  logic             at_bot;
  logic             boundary;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             ovf_next;

  assign at_top = (q == MAX);
  assign at_bot = (q == '0);
  assign tc     = up_dn ? at_top : at_bot;

  // A boundary event only happens on an edge where counting actually wins priority.
  assign boundary = en && !clr && !load && tc;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = (load_val <= MAX) ? load_val : MAX;
    end else if (en) begin
      if (up_dn) begin
        if (!at_top)       q_next = q + 1'b1;
        else if (!SATURATE) q_next = '0;
      end else begin
        if (!at_bot)       q_next = q - 1'b1;
        else if (!SATURATE) q_next = MAX;
      end
      wrap_next = boundary;
    end
  end

  // Setting the sticky flag takes precedence over clearing it on the same edge.
  always_comb begin
    ovf_next = ovf;
    if (boundary)     ovf_next = 1'b1;
    else if (ovf_clr) ovf_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: three instances (mod-10 wrap, mod-10
// saturate, mod-16 wrap) share one set of inputs; each task checks its own scenario.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en, up_dn, ovf_clr;
  logic [3:0] load_val;

  logic [3:0] q_a, q_s, q_f;
  logic       tc_a, tc_s, tc_f;
  logic       wrap_a, wrap_s, wrap_f;
  logic       ovf_a, ovf_s, ovf_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .q(q_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s));

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_f (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .q(q_f), .tc(tc_f), .wrap(wrap_f), .ovf(ovf_f));

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] v,
                       input logic e, input logic u, input logic oc);
    clr = c; load = l; load_val = v; en = e; up_dn = u; ovf_clr = oc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 4'd0, 0, 0, 0);
    #2;
    total++; if (q_a !== 4'd0) begin bad++; $display("FAIL reset_q actual=%0d required=0", q_a); end
    total++; if (wrap_a !== 1'b0 || wrap_s !== 1'b0 || wrap_f !== 1'b0) begin
      bad++; $display("FAIL reset_wrap actual=%b%b%b required=000", wrap_a, wrap_s, wrap_f); end
    total++; if (ovf_a !== 1'b0 || ovf_s !== 1'b0 || ovf_f !== 1'b0) begin
      bad++; $display("FAIL reset_ovf actual=%b%b%b required=000", ovf_a, ovf_s, ovf_f); end
    total++; if (tc_a !== 1'b1) begin bad++; $display("FAIL reset_tc_down actual=%b required=1", tc_a); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (q_a !== 4'd0) begin bad++; $display("FAIL reset_hold_q actual=%0d required=0", q_a); end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q;
    drive(0, 0, 4'd0, 1, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_q = 4'(i % 10);
      total++; if (q_a !== exp_q) begin bad++; $display("FAIL up_q step=%0d actual=%0d required=%0d", i, q_a, exp_q); end
      total++; if (wrap_a !== (i == 10)) begin bad++; $display("FAIL up_wrap step=%0d actual=%b required=%b", i, wrap_a, (i == 10)); end
      total++; if (tc_a !== (exp_q == 4'd9)) begin bad++; $display("FAIL up_tc step=%0d actual=%b required=%b", i, tc_a, (exp_q == 4'd9)); end
    end
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL up_ovf actual=%b required=1", ovf_a); end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_q [4] = '{4'd9, 4'd9, 4'd9, 4'd9};
    logic       exp_w [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    drive(0, 1, 4'd8, 0, 1, 1);
    step();
    total++; if (q_s !== 4'd8 || ovf_s !== 1'b0) begin
      bad++; $display("FAIL sat_load q=%0d ovf=%b required q=8 ovf=0", q_s, ovf_s); end
    drive(0, 0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (q_s !== exp_q[i] || wrap_s !== exp_w[i]) begin
        bad++; $display("FAIL sat_up step=%0d q=%0d wrap=%b required q=%0d wrap=%b", i, q_s, wrap_s, exp_q[i], exp_w[i]); end
    end
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL sat_ovf actual=%b required=1", ovf_s); end
    up_dn = 1'b0;
    step();
    total++; if (q_s !== 4'd8 || wrap_s !== 1'b0) begin
      bad++; $display("FAIL sat_down1 q=%0d wrap=%b required q=8 wrap=0", q_s, wrap_s); end
    step();
    total++; if (q_s !== 4'd7) begin bad++; $display("FAIL sat_down2 actual=%0d required=7", q_s); end
  endtask

  task automatic test_count_down();
    drive(0, 1, 4'd1, 0, 0, 0);
    step();
    total++; if (q_a !== 4'd1) begin bad++; $display("FAIL down_load actual=%0d required=1", q_a); end
    drive(0, 0, 4'd0, 1, 0, 0);
    step();
    total++; if (q_a !== 4'd0 || wrap_a !== 1'b0 || tc_a !== 1'b1) begin
      bad++; $display("FAIL down_zero q=%0d wrap=%b tc=%b required q=0 wrap=0 tc=1", q_a, wrap_a, tc_a); end
    step();
    total++; if (q_a !== 4'd9 || wrap_a !== 1'b1) begin
      bad++; $display("FAIL down_wrap q=%0d wrap=%b required q=9 wrap=1", q_a, wrap_a); end
    step();
    total++; if (q_a !== 4'd8 || wrap_a !== 1'b0 || tc_a !== 1'b0) begin
      bad++; $display("FAIL down_after q=%0d wrap=%b tc=%b required q=8 wrap=0 tc=0", q_a, wrap_a, tc_a); end
  endtask

  task automatic test_priority();
    drive(0, 1, 4'd13, 0, 1, 0);
    step();
    total++; if (q_a !== 4'd9 || q_f !== 4'd13) begin
      bad++; $display("FAIL load_clamp q_a=%0d q_f=%0d required 9 13", q_a, q_f); end
    drive(0, 1, 4'd5, 1, 1, 0);
    step();
    total++; if (q_a !== 4'd5 || wrap_a !== 1'b0) begin
      bad++; $display("FAIL load_over_en q=%0d wrap=%b required q=5 wrap=0", q_a, wrap_a); end
    drive(1, 1, 4'd5, 1, 1, 0);
    step();
    total++; if (q_a !== 4'd0 || q_s !== 4'd0 || q_f !== 4'd0) begin
      bad++; $display("FAIL clr_first q=%0d/%0d/%0d required 0/0/0", q_a, q_s, q_f); end
  endtask

  task automatic test_sticky_ovf();
    drive(0, 0, 4'd0, 0, 1, 1);
    step();
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_quiet_clr1 actual=%b required=0", ovf_a); end
    drive(0, 1, 4'd9, 0, 1, 0);
    step();
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_load_no_set actual=%b required=0", ovf_a); end
    drive(0, 0, 4'd0, 1, 1, 0);
    step();
    total++; if (q_a !== 4'd0 || ovf_a !== 1'b1) begin
      bad++; $display("FAIL ovf_set q=%0d ovf=%b required q=0 ovf=1", q_a, ovf_a); end
    drive(0, 0, 4'd0, 1, 0, 1);
    step();
    total++; if (q_a !== 4'd9 || ovf_a !== 1'b1 || wrap_a !== 1'b1) begin
      bad++; $display("FAIL ovf_set_wins q=%0d ovf=%b wrap=%b required q=9 ovf=1 wrap=1", q_a, ovf_a, wrap_a); end
    drive(1, 0, 4'd0, 0, 0, 0);
    step();
    total++; if (q_a !== 4'd0 || ovf_a !== 1'b1 || wrap_a !== 1'b0) begin
      bad++; $display("FAIL ovf_clr_keeps q=%0d ovf=%b wrap=%b required q=0 ovf=1 wrap=0", q_a, ovf_a, wrap_a); end
    drive(0, 0, 4'd0, 0, 0, 1);
    step();
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_quiet_clr2 actual=%b required=0", ovf_a); end
  endtask

  task automatic test_full_range_and_async_reset();
    drive(0, 1, 4'd15, 0, 1, 1);
    step();
    total++; if (q_f !== 4'd15 || tc_f !== 1'b1) begin
      bad++; $display("FAIL full_load q=%0d tc=%b required q=15 tc=1", q_f, tc_f); end
    drive(0, 0, 4'd0, 1, 1, 0);
    step();
    total++; if (q_f !== 4'd0 || wrap_f !== 1'b1 || ovf_f !== 1'b1) begin
      bad++; $display("FAIL full_wrap q=%0d wrap=%b ovf=%b required q=0 wrap=1 ovf=1", q_f, wrap_f, ovf_f); end
    drive(0, 1, 4'd7, 0, 1, 0);
    step();
    total++; if (q_f !== 4'd7) begin bad++; $display("FAIL full_load7 actual=%0d required=7", q_f); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (q_f !== 4'd0 || ovf_f !== 1'b0 || wrap_f !== 1'b0) begin
      bad++; $display("FAIL async_reset q=%0d ovf=%b wrap=%b required q=0 ovf=0 wrap=0", q_f, ovf_f, wrap_f); end
    drive(0, 0, 4'd0, 1, 1, 0);
    #1;
    rst_n = 1'b1;
    step();
    total++; if (q_f !== 4'd1 || q_a !== 4'd1) begin
      bad++; $display("FAIL resume q_f=%0d q_a=%0d required 1 1", q_f, q_a); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_saturate();
    test_count_down();
    test_priority();
    test_sticky_ovf();
    test_full_range_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's fixed 4-bit free-running up counter.
- Adds: configurable width and modulus, up/down direction, count enable, synchronous clear and parallel load, wrap or saturate mode, terminal-count and wrap/overflow flags.
- Used as a general event/timebase counter in datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits.
- MODULUS, 256, count range is 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**WIDTH. Elaboration fails outside this range.
- SATURATE, 0:
  - 0: wrap at the boundaries.
  - 1: hold at the boundary value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of the count.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- ovf_clr  in  1  clears the sticky overflow flag.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal count for the current direction (combinational).
- wrap  out  1  registered one-cycle boundary-event pulse.
- ovf  out  1  sticky boundary-event flag (registered).

Behaviour:
- Reset: clocked with clk; reset is rst_n, asynchronous, active-low. While rst_n = 0: q = 0, wrap = 0, ovf = 0, regardless of clk.
- Priority per rising edge: clr > load > en. When none is active, q holds.
- clr: q <= 0, wrap <= 0. ovf is unaffected.
- load:
  - q <= load_val if load_val <= MODULUS-1.
  - Otherwise q <= MODULUS-1 (clamp).
  - wrap <= 0. A load never sets ovf.
- en with up_dn = 1:
  - If q < MODULUS-1: q <= q+1.
  - If q = MODULUS-1: boundary event. q <= 0 when SATURATE = 0; q holds MODULUS-1 when SATURATE = 1.
- en with up_dn = 0:
  - If q > 0: q <= q-1.
  - If q = 0: boundary event. q <= MODULUS-1 when SATURATE = 0; q holds 0 when SATURATE = 1.
- Arithmetic is modulo MODULUS, not 2**WIDTH. When MODULUS = 2**WIDTH, behaviour equals natural binary wrap. No intermediate overflow beyond WIDTH bits.
- Latency: q reflects an enabled step one cycle after the edge on which en is sampled high. An en held high gives one step per clock.
- tc:
  - tc = 1 when (up_dn = 1 and q = MODULUS-1) or (up_dn = 0 and q = 0).
  - Combinational from q and up_dn. Independent of en.
- wrap:
  - Set to 1 on the edge where a boundary event occurs, in both wrap and saturate modes.
  - Cleared on the next edge unless another boundary event occurs, so it stays high continuously while saturated with en = 1.
- ovf:
  - Set on any boundary event edge.
  - Cleared by ovf_clr on an edge with no boundary event.
  - Set wins over ovf_clr when both occur on the same edge.
- Direction change mid-count: takes effect on the next enabled edge. No glitch state and no skipped value.
- Reset mid-operation: asynchronous assertion forces the reset values immediately. Counting resumes from 0 on the first edge after rst_n deasserts.
- No internal state beyond q, wrap and ovf.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
1. Reset, then en=1, up_dn=1 for 12 cycles -> q: 1..9, 0, 1, 2; wrap high only in the cycle after 9->0; tc=1 while q=9; ovf=1 afterwards.
2. SATURATE=1, load_val=8 with load=1, then en=1, up_dn=1 for 4 cycles -> q: 8, 9, 9, 9, 9; wrap high for 3 consecutive cycles; ovf=1. Then up_dn=0 -> q: 8, 7.
3. Down count from load_val=1: en=1, up_dn=0 -> q: 0, 9, 8; wrap pulses once after 0->9; tc=1 when q=0.
4. Priority and clamp:
   - load_val=13 -> q=9 (clamped).
   - clr=1, load=1, en=1 on the same edge -> q=0.
   - load=1, en=1, load_val=5 -> q=5, not 6.
5. Sticky flag: create a boundary event, then assert ovf_clr on the same edge as another boundary event -> ovf stays 1. Assert ovf_clr on a quiet edge -> ovf=0.
6. WIDTH=4, MODULUS=16, q=15, en=1, up_dn=1 -> q=0, wrap=1. Async rst_n pulse between clock edges at q=7 -> q=0 immediately, ovf=0.
